// File: rtl/stw_bist_if.sv
// STW test-port bus between the BIST controller (master) and the systolic array (slave).
interface stw_bist_if #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] STW_mult_op1;
  logic [WORD_SIZE-1:0] STW_mult_op2;
  logic [WORD_SIZE-1:0] STW_add_op;
  logic [WORD_SIZE-1:0] STW_expected;
  logic                 STW_test_load_en;
  logic                 STW_start;
  logic                 STW_complete_in;
  logic [ROWS*COLS-1:0] STW_result_in;

  modport master (
    output STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected,
    output STW_test_load_en, STW_start,
    input  STW_complete_in, STW_result_in
  );

  modport slave (
    input  STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected,
    input  STW_test_load_en, STW_start,
    output STW_complete_in, STW_result_in
  );
endinterface

// File: rtl/stw_bist_controller.sv
// Self-test sequencer for the systolic array STW port: plays a fixed 4-vector table
// and accumulates a sticky per-PE fault map for the repair logic.
module stw_bist_controller #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bist_start,
  output logic                              bist_busy,
  output logic                              bist_done,
  output logic                              test_mode,
  stw_bist_if.master                        stw,
  output logic [ROWS*COLS-1:0]              fault_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]    fault_count,
  output logic                              any_fault,
  output logic                              timeout_err
);
  localparam int PE = ROWS * COLS;
  localparam int CW = $clog2(PE + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [TW-1:0]          TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [2*WORD_SIZE-1:0] PAT_WIDE   = {WORD_SIZE{2'b01}};
  localparam logic [WORD_SIZE-1:0]   PAT_A      = PAT_WIDE[WORD_SIZE-1:0];
  localparam logic [WORD_SIZE-1:0]   PAT_B      = ~PAT_A;
  localparam logic [WORD_SIZE-1:0]   W_ONES     = '1;
  localparam logic [WORD_SIZE-1:0]   W_ONE      = WORD_SIZE'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     idx_reg;
  logic [TW-1:0]  timer_reg;
  logic           armed_reg;
  logic [PE-1:0]  fault_map_reg, fault_map_next;
  logic [CW-1:0]  fault_count_reg;
  logic           timeout_err_reg;
  logic           completion;
  logic           timer_expired;
  logic [CW-1:0]  pop_acc [PE+1];

  // A complete still high from the previous vector is ignored until it has dropped once.
  assign completion    = (state_reg == S_WAIT) && armed_reg && stw.STW_complete_in;
  assign timer_expired = (state_reg == S_WAIT) && (timer_reg == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bist_start) state_next = S_LOAD;
      S_LOAD:  state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (completion)         state_next = (idx_reg == 2'd3) ? S_DONE : S_LOAD;
        else if (timer_expired) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stw.STW_mult_op1     = '0;
    stw.STW_mult_op2     = '0;
    stw.STW_add_op       = '0;
    stw.STW_expected     = '0;
    stw.STW_test_load_en = (state_reg == S_LOAD);
    stw.STW_start        = (state_reg == S_START);
    bist_busy            = (state_reg != S_IDLE);
    test_mode            = (state_reg != S_IDLE);
    bist_done            = (state_reg == S_DONE);
    if (state_reg == S_LOAD || state_reg == S_START || state_reg == S_WAIT) begin
      case (idx_reg)
        2'd1: begin
          stw.STW_mult_op1 = W_ONES;
          stw.STW_mult_op2 = W_ONES;
          stw.STW_expected = W_ONE;
        end
        2'd2: begin
          stw.STW_mult_op1 = PAT_A;
          stw.STW_mult_op2 = W_ONE;
          stw.STW_add_op   = PAT_B;
          stw.STW_expected = W_ONES;
        end
        2'd3: begin
          stw.STW_mult_op1 = W_ONE;
          stw.STW_mult_op2 = W_ONE;
          stw.STW_add_op   = W_ONES;
        end
        default: ;
      endcase
    end
  end

  // Completion beats a simultaneous timeout.
  always_comb begin
    fault_map_next = fault_map_reg;
    case (state_reg)
      S_IDLE: if (bist_start) fault_map_next = '0;
      S_WAIT: begin
        if (completion)         fault_map_next = fault_map_reg | stw.STW_result_in;
        else if (timer_expired) fault_map_next = '1;
      end
      default: ;
    endcase
  end

  assign pop_acc[0] = '0;
  for (genvar gi = 0; gi < PE; gi++) begin : g_pop
    assign pop_acc[gi+1] = pop_acc[gi] + CW'(fault_map_next[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg         <= '0;
      timer_reg       <= '0;
      armed_reg       <= 1'b0;
      fault_map_reg   <= '0;
      fault_count_reg <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      fault_map_reg <= fault_map_next;
      case (state_reg)
        S_IDLE: begin
          if (bist_start) begin
            idx_reg         <= '0;
            fault_count_reg <= '0;
            timeout_err_reg <= 1'b0;
          end
        end
        S_START: begin
          timer_reg <= '0;
          armed_reg <= 1'b0;
        end
        S_WAIT: begin
          timer_reg <= timer_reg + 1'b1;
          if (!stw.STW_complete_in) armed_reg <= 1'b1;
          if (completion) begin
            if (idx_reg != 2'd3) idx_reg <= idx_reg + 2'd1;
          end else if (timer_expired) begin
            timeout_err_reg <= 1'b1;
          end
          // Count is latched on entry to DONE so it is already valid alongside bist_done.
          if (state_next == S_DONE) fault_count_reg <= pop_acc[PE];
        end
        default: ;
      endcase
    end
  end

  assign fault_map   = fault_map_reg;
  assign fault_count = fault_count_reg;
  assign any_fault   = |fault_map_reg;
  assign timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_stw_bist_controller.sv
// Scoreboard bench for stw_bist_controller: a behavioural array drives complete/result
// from per-vector waveforms; expected loads and run summaries are queued and checked on output.
module tb_stw_bist_controller;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 16;
  localparam int TO   = 8;
  localparam int PE   = ROWS * COLS;
  localparam int CW   = $clog2(PE + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          bist_start;
  logic          bist_busy, bist_done, test_mode, any_fault, timeout_err;
  logic [PE-1:0] fault_map;
  logic [CW-1:0] fault_count;

  stw_bist_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W)) stw ();

  stw_bist_controller #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bist_start(bist_start), .bist_busy(bist_busy),
    .bist_done(bist_done), .test_mode(test_mode), .stw(stw),
    .fault_map(fault_map), .fault_count(fault_count), .any_fault(any_fault),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] op1, op2, add, exp; } load_t;
  typedef struct { logic [PE-1:0] fm; int cnt; logic af; logic to; int len; } done_t;

  load_t load_q[$];
  done_t done_q[$];

  // Per-vector array behaviour: complete high for h WAIT cycles, low for l, then high.
  int            cfg_h[4], cfg_l[4];
  bit            cfg_hang[4];
  logic [PE-1:0] cfg_res[4];

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, start_cnt = 0;
  logic [PE-1:0] exp_fm;
  int            exp_cnt;
  logic          exp_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic load_t table_entry(input int v);
    load_t e;
    logic [W-1:0] a, n;
    a = '0;
    for (int i = 0; i < W; i += 2) a[i] = 1'b1;
    n = '1;
    case (v)
      0: begin e.op1 = '0; e.op2 = '0; e.add = '0; e.exp = '0; end
      1: begin e.op1 = n;  e.op2 = n;  e.add = '0; e.exp = W'(1); end
      2: begin e.op1 = a;  e.op2 = W'(1); e.add = ~a; e.exp = n; end
      default: begin e.op1 = W'(1); e.op2 = W'(1); e.add = n; e.exp = '0; end
    endcase
    return e;
  endfunction

  // Reference model: which vectors get loaded, what the fault map ends as, how long the run is.
  task automatic expect_run(input int abort_at);
    logic [PE-1:0] fm;
    bit to, ok;
    int len;
    done_t d;
    fm = '0; to = 0; len = 0;
    for (int v = 0; v < 4; v++) begin
      load_q.push_back(table_entry(v));
      if (v == abort_at) return;
      ok = !cfg_hang[v] && cfg_l[v] > 0 && (cfg_h[v] + cfg_l[v] + 1) <= TO;
      if (ok) begin
        fm |= cfg_res[v];
        len += 2 + cfg_h[v] + cfg_l[v] + 1;
      end else begin
        fm = '1; to = 1;
        len += 2 + TO;
        break;
      end
    end
    len += 1;
    d.fm = fm; d.cnt = $countones(fm); d.af = |fm; d.to = to; d.len = len;
    done_q.push_back(d);
    exp_fm = fm; exp_cnt = d.cnt; exp_to = to;
  endtask

  // Behavioural array
  int drv_j = 0, drv_vec = 0, drv_loads = 0;
  always @(negedge clk) begin
    int v;
    if (!bist_busy) drv_loads = 0;
    if (stw.STW_test_load_en) begin
      drv_vec = drv_loads & 3;
      drv_loads++;
    end
    v = drv_vec;
    stw.STW_result_in = PE'($urandom);
    if (stw.STW_start) begin
      drv_j = 0;
      stw.STW_complete_in = (cfg_h[v] > 0);
    end else begin
      drv_j++;
      if (drv_j <= cfg_h[v])                  stw.STW_complete_in = 1'b1;
      else if (drv_j <= cfg_h[v] + cfg_l[v]) stw.STW_complete_in = 1'b0;
      else                                    stw.STW_complete_in = !cfg_hang[v];
      if (!cfg_hang[v] && cfg_l[v] > 0 && drv_j == cfg_h[v] + cfg_l[v] + 1)
        stw.STW_result_in = cfg_res[v];
    end
  end

  // Monitor / scoreboard
  int    busy_run = 0;
  bit    prev_load = 0;
  load_t last_ld;
  always @(negedge clk) begin
    done_t d;
    if (!bist_busy) busy_run = 0;
    else            busy_run++;
    if (stw.STW_test_load_en) begin
      if (load_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_load: got load_en=1, want no load");
      end else begin
        last_ld = load_q.pop_front();
        chk("load_op1", stw.STW_mult_op1, last_ld.op1);
        chk("load_op2", stw.STW_mult_op2, last_ld.op2);
        chk("load_add", stw.STW_add_op, last_ld.add);
        chk("load_exp", stw.STW_expected, last_ld.exp);
        $display("load  op1=%h op2=%h add=%h exp=%h", stw.STW_mult_op1, stw.STW_mult_op2,
                 stw.STW_add_op, stw.STW_expected);
      end
    end
    if (stw.STW_start) begin
      start_cnt++;
      chk("start_follows_load", 32'(prev_load), 32'd1);
      chk("start_hold_op1", stw.STW_mult_op1, last_ld.op1);
      chk("start_hold_exp", stw.STW_expected, last_ld.exp);
    end
    if (bist_done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got bist_done=1, want no done");
      end else begin
        d = done_q.pop_front();
        chk("done_fault_map", fault_map, d.fm);
        chk("done_fault_count", fault_count, d.cnt);
        chk("done_any_fault", any_fault, d.af);
        chk("done_timeout_err", timeout_err, d.to);
        chk("done_run_length", busy_run, d.len);
        chk("done_test_mode", test_mode, 32'd1);
        $display("done  fault_map=%h count=%0d timeout=%0b cycles=%0d", fault_map,
                 fault_count, timeout_err, busy_run);
      end
    end
    prev_load = stw.STW_test_load_en;
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, bist_busy, 0);
    chk({tag, "_done"}, bist_done, 0);
    chk({tag, "_test_mode"}, test_mode, 0);
    chk({tag, "_op1"}, stw.STW_mult_op1, 0);
    chk({tag, "_op2"}, stw.STW_mult_op2, 0);
    chk({tag, "_add"}, stw.STW_add_op, 0);
    chk({tag, "_exp"}, stw.STW_expected, 0);
    chk({tag, "_load_en"}, stw.STW_test_load_en, 0);
    chk({tag, "_start"}, stw.STW_start, 0);
    chk({tag, "_fault_map"}, fault_map, 0);
    chk({tag, "_fault_count"}, fault_count, 0);
    chk({tag, "_any_fault"}, any_fault, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic set_clean(input int l);
    for (int v = 0; v < 4; v++) begin
      cfg_h[v] = 0; cfg_l[v] = l; cfg_hang[v] = 0; cfg_res[v] = '0;
    end
  endtask

  task automatic wait_starts(input int target);
    int guard = 0;
    while (start_cnt < target && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (start_cnt < target) begin
      n_checks++; n_fail++;
      $display("FAIL start_wait: got %0d starts, want %0d", start_cnt, target);
    end
  endtask

  task automatic do_run(input int abort_at, input bit poke);
    int base_done, base_start, guard;
    expect_run(abort_at);
    base_done  = done_cnt;
    base_start = start_cnt;
    @(negedge clk); bist_start = 1'b1;
    @(negedge clk); bist_start = 1'b0;
    if (poke) begin
      wait_starts(base_start + 2);
      @(negedge clk); bist_start = 1'b1;
      @(negedge clk); bist_start = 1'b0;
    end
    if (abort_at >= 0) begin
      wait_starts(base_start + abort_at + 1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check_all_zero("abort");
      rst = 1'b0;
      $display("abort reset during WAIT of V%0d", abort_at);
      return;
    end
    guard = 0;
    while (done_cnt == base_done && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt == base_done) begin
      n_checks++; n_fail++;
      $display("FAIL done_wait: got no bist_done, want one within 2000 cycles");
    end
    repeat (3) @(negedge clk);
    chk("hold_fault_map", fault_map, exp_fm);
    chk("hold_fault_count", fault_count, exp_cnt);
    chk("hold_timeout_err", timeout_err, exp_to);
    chk("hold_any_fault", any_fault, |exp_fm);
    chk("idle_busy", bist_busy, 0);
    chk("idle_op1", stw.STW_mult_op1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bist_start = 1'b0;
    stw.STW_complete_in = 1'b0; stw.STW_result_in = '0;
    set_clean(2);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    set_clean(2);
    do_run(-1, 0);

    set_clean(2);
    cfg_res[0] = 16'h0400; cfg_res[2] = 16'h0020; cfg_res[3] = 16'h0400;
    do_run(-1, 0);

    set_clean(2);
    cfg_hang[1] = 1;
    do_run(-1, 0);

    set_clean(2);
    cfg_h[1] = 2; cfg_l[1] = 1; cfg_res[1] = 16'h0008;
    do_run(-1, 0);

    set_clean(3);
    for (int v = 0; v < 4; v++) cfg_res[v] = PE'($urandom_range(1, 16'hFFFF));
    do_run(-1, 1);
    set_clean(2);
    do_run(-1, 0);

    set_clean(2);
    cfg_l[0] = TO - 1; cfg_l[2] = TO; cfg_res[0] = 16'h8001;
    do_run(-1, 0);

    set_clean(4);
    cfg_res[0] = 16'h0002;
    do_run(2, 0);
    set_clean(2);
    do_run(-1, 0);

    for (int r = 0; r < 10; r++) begin
      for (int v = 0; v < 4; v++) begin
        cfg_h[v]    = $urandom_range(0, 2);
        cfg_l[v]    = $urandom_range(0, TO);
        cfg_hang[v] = ($urandom_range(0, 9) == 0);
        cfg_res[v]  = PE'($urandom & $urandom & $urandom);
      end
      do_run(-1, 0);
    end

    repeat (5) @(negedge clk);
    chk("load_queue_empty", load_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
